seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have parameter SIGNED_CMP, default 0, 1 = opcode 1110 compares two's-complement.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts new operation.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Sel  input  4  opcode.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Answer  output  WIDTH  result.
REQ-013 Carryout  output  1  carry / borrow / overflow / divide-error flag.
REQ-014 Zero  output  1  Answer == 0.

Function
REQ-015 Accept SHALL occur on cycle with in_valid && in_ready; A, B, Sel captured into internal registers; later input changes ignored.
REQ-016 FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 Single-cycle opcodes: IDLE -accept-> DONE; out_valid asserted the cycle after accept.
REQ-018 Mul/div opcodes: IDLE -accept-> EXEC for exactly WIDTH cycles -> DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-019 DONE -> IDLE on out_ready; Answer/Carryout/Zero SHALL hold stable while out_valid && !out_ready.
REQ-020 Opcodes: 0000 A+B (Carryout = carry-out); 0001 A-B (Carryout = borrow, 1 when A<B unsigned); 0010 A*B shift-add (Answer = low WIDTH bits, Carryout = OR of high WIDTH bits); 0011 A/B restoring (Answer = quotient, Carryout = 0).
REQ-021 Opcodes: 0100 AND; 0101 OR; 0110 XOR; 0111 XNOR; 1000 A<<1 (Carryout = A[MSB]); 1001 A>>1 logical (Carryout = A[0]); 1010 rotate left 1; 1011 rotate right 1; 1100 NAND; 1101 NOR; 1110 Answer = (A>B) zero-extended; 1111 Answer = (A==B) zero-extended; Carryout = 0 for all except 1000/1001.
REQ-022 Divide by zero SHALL complete in WIDTH cycles with Answer = all ones, Carryout = 1.
REQ-023 Zero SHALL be computed from the registered Answer, valid whenever out_valid.
REQ-024 in_valid while busy SHALL be ignored (not queued); no result lost or duplicated.
REQ-025 All arithmetic unsigned unless SIGNED_CMP governs 1110; no width truncation other than stated.

Reset
REQ-026 rst SHALL force IDLE at next edge, aborting any EXEC or DONE operation; abort result never presented.
REQ-027 After reset: in_ready = 1, out_valid = 0, Answer = 0, Carryout = 0, Zero = 1, internal counters/partials = 0.
REQ-028 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: opcodes 0010/0011 behave per REQ-018/020/022.
REQ-030 Macro undefined: multiplier/divider absent; 0010/0011 complete single-cycle with Answer = 0, Carryout = 1 (illegal-op indication); EXEC unreachable.

Structure
REQ-031 Package seq_alu_pkg SHALL hold opcode constants (OP_ADD ... OP_EQ) and FSM state enumeration.
REQ-032 Iterative multiply/divide SHALL be sub-module seq_alu_muldiv (start, op, operands, done pulse, result, flag), instantiated only under SEQ_ALU_MULDIV_EN.

Verification
REQ-033 WIDTH=8: A=10, B=20, Sel=0000 -> out_valid 1 cycle later, Answer=30, Carryout=0, Zero=0.
REQ-034 A=30, B=20, Sel=0001 -> Answer=10, Carryout=0; A=20, B=30 -> Answer=0xF6, Carryout=1.
REQ-035 MULDIV_EN: A=11, B=3, Sel=0010 -> out_valid exactly 9 cycles after accept, Answer=33, Carryout=0; A=100, B=4, Sel=0011 -> Answer=25; B=0 -> Answer=0xFF, Carryout=1.
REQ-036 A=0xE3, B=0xAA, Sel=0100/0101/0110 -> 0xA2/0xEB/0x49; A=0xF0, Sel=1000 -> Answer=0xE0, Carryout=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles after result -> Answer/flags stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst asserted mid-EXEC of 0010 -> next cycle in_ready=1, out_valid=0, Answer=0, no stale result appears; repeat with WIDTH=16 for REQ-033/035.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
// The multiply/divide option is controlled by the SEQ_ALU_MULDIV_EN macro.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    localparam logic [3:0]
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_XNOR = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_NAND = 4'hC,
        OP_NOR  = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Only built when SEQ_ALU_MULDIV_EN is defined.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic                 busy_q, busy_d;
    logic                 div_q, div_d;
    logic                 dbz_q, dbz_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]     aux_q, aux_d;
    logic [WIDTH:0]       rem_sh, trial;

    // Multiply: acc = product, opd = shifting multiplicand, aux = multiplier.
    // Divide:   acc = {remainder, quotient}, opd[WIDTH-1:0] = divisor.
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        dbz_d  = dbz_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opd_d  = opd_q;
        aux_d  = aux_q;
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opd_q[WIDTH-1:0]};

        if (start) begin
            busy_d = 1'b1;
            div_d  = (op == OP_DIV);
            dbz_d  = (b == '0);
            cnt_d  = '0;
            acc_d  = (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : '0;
            opd_d  = {{WIDTH{1'b0}}, (op == OP_DIV) ? b : a};
            aux_d  = b;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                if (!trial[WIDTH])
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                if (aux_q[0])
                    acc_d = acc_q + opd_q;
                opd_d = {opd_q[2*WIDTH-2:0], 1'b0};
                aux_d = {1'b0, aux_q[WIDTH-1:1]};
            end
            if (cnt_q == LAST)
                busy_d = 1'b0;
        end
    end

    // Result is taken from the final iteration's next value so the top can
    // latch it on the same edge the last step completes.
    assign done   = busy_q && (cnt_q == LAST);
    assign result = (div_q && dbz_q) ? '1 : acc_d[WIDTH-1:0];
    assign flag   = div_q ? dbz_q : |acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            dbz_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opd_q  <= '0;
            aux_q  <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            dbz_q  <= dbz_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opd_q  <= opd_d;
            aux_q  <= aux_d;
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake on both sides.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide unit.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Answer,
    output logic             Carryout,
    output logic             Zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] answer_q, answer_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] alu_ans;
    logic             alu_c;
    logic [WIDTH:0]   sum, diff;
    logic             gt;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    always_comb begin
        alu_ans = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        gt      = (SIGNED_CMP != 0) ? ($signed(A) > $signed(B)) : (A > B);
        case (Sel)
            OP_ADD:  {alu_c, alu_ans} = sum;
            OP_SUB:  {alu_c, alu_ans} = diff;
            OP_AND:  alu_ans = A & B;
            OP_OR:   alu_ans = A | B;
            OP_XOR:  alu_ans = A ^ B;
            OP_XNOR: alu_ans = ~(A ^ B);
            OP_SHL:  begin alu_ans = {A[WIDTH-2:0], 1'b0}; alu_c = A[WIDTH-1]; end
            OP_SHR:  begin alu_ans = {1'b0, A[WIDTH-1:1]}; alu_c = A[0]; end
            OP_ROL:  alu_ans = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  alu_ans = {A[0], A[WIDTH-1:1]};
            OP_NAND: alu_ans = ~(A & B);
            OP_NOR:  alu_ans = ~(A | B);
            OP_GT:   alu_ans = WIDTH'(gt);
            OP_EQ:   alu_ans = WIDTH'(A == B);
            // Multiply/divide reaching here means the unit is not built.
            default: begin alu_ans = '0; alu_c = 1'b1; end
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic             md_start, md_done, md_flag;
    logic [WIDTH-1:0] md_result;

    assign md_start = (state_q == ST_IDLE) && in_valid && is_muldiv(Sel);

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (Sel),
        .a      (A),
        .b      (B),
        .done   (md_done),
        .result (md_result),
        .flag   (md_flag)
    );
`endif

    always_comb begin
        state_d  = state_q;
        answer_d = answer_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_DONE;
                    answer_d = alu_ans;
                    carry_d  = alu_c;
`ifdef SEQ_ALU_MULDIV_EN
                    if (is_muldiv(Sel)) begin
                        state_d  = ST_EXEC;
                        answer_d = answer_q;
                        carry_d  = carry_q;
                    end
`endif
                end
            end
            ST_EXEC: begin
`ifdef SEQ_ALU_MULDIV_EN
                if (md_done) begin
                    state_d  = ST_DONE;
                    answer_d = md_result;
                    carry_d  = md_flag;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    // NOTE: the result registers are reset along with the state, so an
    // aborted operation can never leave a stale Answer visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            answer_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            answer_q <= answer_d;
            carry_q  <= carry_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Answer    = answer_q;
    assign Carryout  = carry_q;
    assign Zero      = (answer_q == '0);

endmodule
